// File: rtl/mouse_pos_sync_if.sv
// Bundle between the mouse controller, the vertical timing and the cursor overlay.
// The master side drives raw coordinates and vblank; the slave side returns the committed position.
interface mouse_pos_sync_if;
    logic [11:0] xpos_in;
    logic [11:0] ypos_in;
    logic        pos_valid;
    logic        vblnk_in;
    logic [11:0] xpos;
    logic [11:0] ypos;
    logic        cursor_en;
    logic        frame_tick;

    modport master (
        output xpos_in, ypos_in, pos_valid, vblnk_in,
        input  xpos, ypos, cursor_en, frame_tick
    );

    modport slave (
        input  xpos_in, ypos_in, pos_valid, vblnk_in,
        output xpos, ypos, cursor_en, frame_tick
    );
endinterface

// File: rtl/mouse_pos_sync.sv
// Clamps raw mouse coordinates and commits them to the overlay only at vblank start.
// Define MOUSE_AUTOHIDE_EN to hide the cursor after HIDE_FRAMES idle committed frames.
module mouse_pos_sync #(
    parameter int H_MAX       = 799,
    parameter int V_MAX       = 599,
    parameter int HIDE_FRAMES = 180
) (
    input  logic             pclk,
    input  logic             rst_n,
    mouse_pos_sync_if.slave  bus
);
    localparam logic [1:0] S_SYNC   = 2'd0;
    localparam logic [1:0] S_ACTIVE = 2'd1;
    localparam logic [1:0] S_COMMIT = 2'd2;
    localparam logic [1:0] S_BLANK  = 2'd3;

    localparam logic [11:0] H_LIM = 12'(H_MAX);
    localparam logic [11:0] V_LIM = 12'(V_MAX);

    if (HIDE_FRAMES < 1 || HIDE_FRAMES > 255) begin : gen_bad_hide
        $error("HIDE_FRAMES must be within 1..255");
    end

    logic [1:0]  state_reg;
    logic [1:0]  state_next;
    logic        pend_reg;
    logic [11:0] pend_x_reg;
    logic [11:0] pend_y_reg;
    logic [11:0] xpos_reg;
    logic [11:0] ypos_reg;
    logic        tick_reg;
    logic [11:0] cx;
    logic [11:0] cy;
    logic        commit;

    assign cx     = (bus.xpos_in > H_LIM) ? H_LIM : bus.xpos_in;
    assign cy     = (bus.ypos_in > V_LIM) ? V_LIM : bus.ypos_in;
    assign commit = (state_reg == S_COMMIT);

    // S_SYNC waits for a falling vblank so the partial frame after reset never commits.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_SYNC:   if (!bus.vblnk_in) state_next = S_ACTIVE;
            S_ACTIVE: if (bus.vblnk_in)  state_next = S_COMMIT;
            S_COMMIT: state_next = S_BLANK;
            S_BLANK:  if (!bus.vblnk_in) state_next = S_ACTIVE;
            default:  state_next = S_SYNC;
        endcase
    end

    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg  <= S_SYNC;
            pend_reg   <= 1'b0;
            pend_x_reg <= '0;
            pend_y_reg <= '0;
            xpos_reg   <= '0;
            ypos_reg   <= '0;
            tick_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            tick_reg  <= commit;
            if (commit && pend_reg) begin
                xpos_reg <= pend_x_reg;
                ypos_reg <= pend_y_reg;
            end
            // A sample arriving in the commit cycle refills the buffer for the next frame.
            if (bus.pos_valid) begin
                pend_x_reg <= cx;
                pend_y_reg <= cy;
                pend_reg   <= 1'b1;
            end else if (commit) begin
                pend_reg <= 1'b0;
            end
        end
    end

`ifdef MOUSE_AUTOHIDE_EN
    localparam logic [7:0] HIDE_LIM = 8'(HIDE_FRAMES);

    logic [7:0] idle_reg;
    logic [7:0] idle_inc;
    logic       cursor_en_reg;

    assign idle_inc = (idle_reg >= HIDE_LIM) ? HIDE_LIM : idle_reg + 8'd1;

    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            idle_reg      <= '0;
            cursor_en_reg <= 1'b1;
        end else if (commit) begin
            if (pend_reg) begin
                idle_reg      <= '0;
                cursor_en_reg <= 1'b1;
            end else begin
                idle_reg <= idle_inc;
                if (idle_inc == HIDE_LIM) cursor_en_reg <= 1'b0;
            end
        end
    end

    assign bus.cursor_en = cursor_en_reg;
`else
    assign bus.cursor_en = 1'b1;
`endif

    assign bus.xpos       = xpos_reg;
    assign bus.ypos       = ypos_reg;
    assign bus.frame_tick = tick_reg;
endmodule

// File: tb/tb_mouse_pos_sync.sv
// Scoreboard bench for mouse_pos_sync: stimulus queues expected commits, a negedge monitor checks them.
module tb_mouse_pos_sync;
    localparam int HIDE = 3;

    typedef struct {
        logic [11:0] x;
        logic [11:0] y;
        logic        en;
        int          due;
    } exp_t;

    logic pclk = 1'b0;
    logic rst_n;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    exp_t exp_q[$];

    // stimulus-side model
    logic        m_pend;
    logic [11:0] m_x, m_y, m_cx, m_cy;
    logic        m_en;
    int          m_cnt;

    // monitor-side view of the last committed outputs
    logic [11:0] cur_x = '0;
    logic [11:0] cur_y = '0;
    logic        cur_en = 1'b1;

    mouse_pos_sync_if bus();

    mouse_pos_sync #(.H_MAX(799), .V_MAX(599), .HIDE_FRAMES(HIDE)) dut (
        .pclk  (pclk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 pclk = ~pclk;
    always @(posedge pclk) cyc <= cyc + 1;

    task automatic step(input int n);
        repeat (n) begin
            @(posedge pclk);
            #1;
        end
    endtask

    task automatic send(input logic [11:0] x, input logic [11:0] y,
                        input logic [11:0] ex, input logic [11:0] ey);
        bus.xpos_in   = x;
        bus.ypos_in   = y;
        bus.pos_valid = 1'b1;
        m_pend = 1'b1;
        m_x    = ex;
        m_y    = ey;
        $display("SEND raw=(%0d,%0d) expect clamped=(%0d,%0d)", x, y, ex, ey);
        step(1);
        bus.pos_valid = 1'b0;
    endtask

    task automatic model_reset();
        m_pend = 1'b0;
        m_cx   = '0;
        m_cy   = '0;
        m_en   = 1'b1;
        m_cnt  = 0;
    endtask

    // Raise vblank; the commit must appear two edges later.
    task automatic rise();
        exp_t e;
        bus.vblnk_in = 1'b1;
        if (m_pend) begin
            m_cx = m_x;
            m_cy = m_y;
            m_pend = 1'b0;
            m_cnt = 0;
            m_en  = 1'b1;
        end else begin
            if (m_cnt < HIDE) m_cnt = m_cnt + 1;
`ifdef MOUSE_AUTOHIDE_EN
            if (m_cnt == HIDE) m_en = 1'b0;
`endif
        end
        e.x   = m_cx;
        e.y   = m_cy;
        e.en  = m_en;
        e.due = cyc + 2;
        exp_q.push_back(e);
    endtask

    task automatic fall();
        bus.vblnk_in = 1'b0;
    endtask

    always @(negedge pclk) begin
        exp_t e;
        if (!rst_n) begin
            checks++;
            if (bus.xpos != 12'd0 || bus.ypos != 12'd0 || bus.cursor_en != 1'b1 || bus.frame_tick != 1'b0) begin
                errors++;
                $display("FAIL reset: got x=%0d y=%0d en=%0b tick=%0b, want x=0 y=0 en=1 tick=0",
                         bus.xpos, bus.ypos, bus.cursor_en, bus.frame_tick);
            end
            cur_x  = '0;
            cur_y  = '0;
            cur_en = 1'b1;
        end else if (bus.frame_tick) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL tick_unexpected: got tick=1 x=%0d y=%0d at cyc=%0d, want no tick",
                         bus.xpos, bus.ypos, cyc);
            end else begin
                e = exp_q.pop_front();
                if (bus.xpos != e.x || bus.ypos != e.y || bus.cursor_en != e.en || cyc != e.due) begin
                    errors++;
                    $display("FAIL commit: got x=%0d y=%0d en=%0b cyc=%0d, want x=%0d y=%0d en=%0b cyc=%0d",
                             bus.xpos, bus.ypos, bus.cursor_en, cyc, e.x, e.y, e.en, e.due);
                end else begin
                    $display("COMMIT ok x=%0d y=%0d en=%0b cyc=%0d", bus.xpos, bus.ypos, bus.cursor_en, cyc);
                end
                cur_x  = e.x;
                cur_y  = e.y;
                cur_en = e.en;
            end
        end else begin
            if (exp_q.size() != 0 && exp_q[0].due <= cyc) begin
                e = exp_q.pop_front();
                checks++;
                errors++;
                $display("FAIL tick_missed: got tick=0 at cyc=%0d, want commit x=%0d y=%0d at cyc=%0d",
                         cyc, e.x, e.y, e.due);
                cur_x  = e.x;
                cur_y  = e.y;
                cur_en = e.en;
            end
            checks++;
            if (bus.xpos != cur_x || bus.ypos != cur_y || bus.cursor_en != cur_en) begin
                errors++;
                $display("FAIL stable: got x=%0d y=%0d en=%0b cyc=%0d, want x=%0d y=%0d en=%0b",
                         bus.xpos, bus.ypos, bus.cursor_en, cyc, cur_x, cur_y, cur_en);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish by 200000ns, want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n         = 1'b0;
        bus.vblnk_in  = 1'b1;
        bus.pos_valid = 1'b0;
        bus.xpos_in   = '0;
        bus.ypos_in   = '0;
        model_reset();
        step(3);
        rst_n = 1'b1;
        step(6);                       // vblank already high: no commit allowed
        fall(); step(5); rise(); step(3); fall();

        step(2); send(12'd100, 12'd200, 12'd100, 12'd200);
        step(5); rise(); step(3); fall();

        step(2); send(12'hFFF, 12'd700, 12'd799, 12'd599);
        step(3); rise(); step(2); fall();

        step(2); send(12'd798, 12'd600, 12'd798, 12'd599);
        step(2); rise(); step(1); fall();  // one-cycle vblank pulse

        step(3); send(12'd800, 12'd0, 12'd799, 12'd0);
        rise(); step(1); fall();

        step(2);
        send(12'd10, 12'd10, 12'd10, 12'd10);
        send(12'd20, 12'd20, 12'd20, 12'd20);
        step(1);
        send(12'd30, 12'd30, 12'd30, 12'd30);
        step(2); rise(); step(1);
        send(12'd5, 12'd5, 12'd5, 12'd5);   // lands in the commit cycle
        step(2); fall();
        step(4); rise(); step(3); fall();

        step(3); send(12'd123, 12'd45, 12'd123, 12'd45);
        step(2);
        rst_n = 1'b0;
        model_reset();
        step(2);
        rst_n = 1'b1;
        step(3); rise(); step(3); fall();

        repeat (4) begin
            step(4); rise(); step(3); fall();
        end
        step(2); send(12'd50, 12'd60, 12'd50, 12'd60);
        step(3); rise(); step(3); fall();
        step(6);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
